// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared single-precision float constants, comparator opcodes and the
// scheduler state type used by fcmp_core and fcmp_sched.
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_pkg;

  // IEEE-754 binary32 field widths
  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  // Comparator opcodes
  localparam logic [1:0] OP_EQ  = 2'b00;
  localparam logic [1:0] OP_LT  = 2'b01;
  localparam logic [1:0] OP_LE  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  // Result-register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } sched_state_t;

  // Exponent all ones with a nonzero mantissa; infinities are not NaN.
  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == EXP_MAX) && (x[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// -----------------------------------------------------------------------------
// fcmp_core
// Purely combinational single-precision comparator.
// Ports:
//   x1, x2 : operands (binary32)
//   op     : OP_EQ / OP_LT / OP_LE / OP_RSV
//   y      : comparison result (0 on NaN or reserved opcode)
//   inv    : either operand NaN, or reserved opcode
// -----------------------------------------------------------------------------
module fcmp_core
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] x1,
  input  logic [FP_W-1:0] x2,
  input  logic [1:0]      op,
  output logic            y,
  output logic            inv
);

  logic            w_nan;
  logic            w_both_zero;
  logic            w_s1;
  logic            w_s2;
  logic [FP_W-2:0] w_m1;
  logic [FP_W-2:0] w_m2;
  logic            w_eq;
  logic            w_lt;

  assign w_s1        = x1[FP_W-1];
  assign w_s2        = x2[FP_W-1];
  assign w_m1        = x1[FP_W-2:0];
  assign w_m2        = x2[FP_W-2:0];
  assign w_nan       = is_nan(x1) || is_nan(x2);
  assign w_both_zero = (w_m1 == '0) && (w_m2 == '0);

  always_comb begin
    // +0 and -0 are the only pair with differing bits that compare equal.
    w_eq = w_both_zero || (x1 == x2);

    // Sign-magnitude ordering; the magnitude field orders infinities correctly.
    if (w_both_zero)     w_lt = 1'b0;
    else if (w_s1 != w_s2) w_lt = w_s1;
    else if (!w_s1)      w_lt = (w_m1 < w_m2);
    else                 w_lt = (w_m1 > w_m2);

    y = 1'b0;
    case (op)
      OP_EQ:   y = w_eq;
      OP_LT:   y = w_lt;
      OP_LE:   y = w_lt || w_eq;
      default: y = 1'b0;
    endcase
    if (w_nan) y = 1'b0;

    inv = w_nan || (op == OP_RSV);
  end

endmodule

// File: rtl/fcmp_sched.sv
// -----------------------------------------------------------------------------
// fcmp_sched
// Round-robin scheduler sharing one fcmp_core among NREQ requesters, with a
// one-deep result register (1-cycle latency, 1 op/cycle) and a saturating
// count of invalid operations.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot)
//   req_op, req_x1, req_x2: per-requester opcode and operands (packed buses)
//   rsp_valid/rsp_ready   : result handshake
//   rsp_y, rsp_id, rsp_inv: result, owning requester, invalid flag
//   inv_cnt               : saturating count of accepted invalid operations
// -----------------------------------------------------------------------------
module fcmp_sched
  import fpu_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [FP_W*NREQ-1:0]    req_x1,
  input  logic [FP_W*NREQ-1:0]    req_x2,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_y,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_inv,
  output logic [CNT_W-1:0]        inv_cnt
);

  localparam int ID_W = $clog2(NREQ);

  sched_state_t r_state;
  sched_state_t w_state_next;

  logic [ID_W-1:0]  r_ptr;
  logic             r_y;
  logic [ID_W-1:0]  r_id;
  logic             r_inv;
  logic [CNT_W-1:0] r_inv_cnt;

  logic [1:0]      w_op_arr [NREQ];
  logic [FP_W-1:0] w_x1_arr [NREQ];
  logic [FP_W-1:0] w_x2_arr [NREQ];

  logic [NREQ-1:0] w_grant;
  logic [ID_W-1:0] w_grant_idx;
  logic            w_found;
  logic            w_slot_free;
  logic            w_accept;
  logic [ID_W:0]   w_ptr_inc;
  logic [ID_W-1:0] w_ptr_next;
  logic            w_y;
  logic            w_inv;

  // Unpack the per-requester buses into arrays for indexed selection.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_arr[gi] = req_op[2*gi +: 2];
    assign w_x1_arr[gi] = req_x1[FP_W*gi +: FP_W];
    assign w_x2_arr[gi] = req_x2[FP_W*gi +: FP_W];
  end

  // Round-robin: first valid requester at or after r_ptr, modulo NREQ.
  always_comb begin
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NREQ)) w_sum = w_sum - (ID_W+1)'(NREQ);
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_idx    = w_idx;
      end
    end
  end

  // Reset blocks the slot so nothing is accepted on a reset edge.
  assign w_slot_free = !rst && ((r_state == ST_EMPTY) || rsp_ready);
  assign req_ready   = w_slot_free ? w_grant : '0;
  assign w_accept    = w_slot_free && w_found;

  assign w_ptr_inc  = {1'b0, w_grant_idx} + 1'b1;
  assign w_ptr_next = (w_ptr_inc == (ID_W+1)'(NREQ)) ? '0 : w_ptr_inc[ID_W-1:0];

  // Only the granted requester's operands reach the comparator.
  fcmp_core u_core (
    .x1  (w_x1_arr[w_grant_idx]),
    .x2  (w_x2_arr[w_grant_idx]),
    .op  (w_op_arr[w_grant_idx]),
    .y   (w_y),
    .inv (w_inv)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (!w_accept && rsp_ready) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_ptr     <= '0;
      r_y       <= 1'b0;
      r_id      <= '0;
      r_inv     <= 1'b0;
      r_inv_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_ptr <= w_ptr_next;
        r_y   <= w_y;
        r_id  <= w_grant_idx;
        r_inv <= w_inv;
        if (w_inv && (r_inv_cnt != '1)) r_inv_cnt <= r_inv_cnt + 1'b1;
      end
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_y     = r_y;
  assign rsp_id    = r_id;
  assign rsp_inv   = r_inv;
  assign inv_cnt   = r_inv_cnt;

endmodule

// File: tb/tb_fcmp_sched.sv
// -----------------------------------------------------------------------------
// tb_fcmp_sched
// Directed self-checking bench for fcmp_sched (NREQ=2). A second instance
// with CNT_W=2 shares the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_fcmp_sched;
  import fpu_pkg::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] req_ready2;
  logic [3:0]      req_op;
  logic [63:0]     req_x1;
  logic [63:0]     req_x2;
  logic            rsp_ready;
  logic            rsp_valid, rsp_y, rsp_inv;
  logic [0:0]      rsp_id;
  logic [15:0]     inv_cnt;
  logic            rsp_valid2, rsp_y2, rsp_inv2;
  logic [0:0]      rsp_id2;
  logic [1:0]      inv_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  fcmp_sched #(.NREQ(NREQ), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_id(rsp_id), .rsp_inv(rsp_inv), .inv_cnt(inv_cnt)
  );

  fcmp_sched #(.NREQ(NREQ), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op),
    .req_x1(req_x1), .req_x2(req_x2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_y(rsp_y2),
    .rsp_id(rsp_id2), .rsp_inv(rsp_inv2), .inv_cnt(inv_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_op[2*r +: 2]  = op;
    req_x1[32*r +: 32] = a;
    req_x2[32*r +: 32] = b;
  endtask

  // Directed comparator vectors on requester 0: op, x1, x2, y, inv
  localparam int NV = 9;
  logic [1:0]  v_op  [NV] = '{OP_LT, OP_LT, OP_LE, OP_LT, OP_LT, OP_LE, OP_EQ, OP_LE, OP_LT};
  logic [31:0] v_x1  [NV] = '{32'hC000_0000, 32'hBF80_0000, 32'h7F80_0000, 32'hFF80_0000,
                             32'h8000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h7F80_0001,
                             32'h3F80_0000};
  logic [31:0] v_x2  [NV] = '{32'hBF80_0000, 32'hC000_0000, 32'h7F80_0000, 32'h0000_0000,
                             32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0001,
                             32'hBF80_0000};
  logic        v_y   [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        v_inv [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_x1    = '0;
    req_x2    = '0;
    rsp_ready = 1'b0;
    tick();
    tick();

    // No grant while reset is high, even with requests pending
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1 chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_y", 32'(rsp_y), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_inv", 32'(rsp_inv), 32'd0);
    chk("rst_cnt", 32'(inv_cnt), 32'd0);
    rst       = 1'b0;
    req_valid = '0;

    // Both requesters streaming: grants alternate 0,1,0,1 at one per cycle
    set_req(0, OP_EQ, 32'h3F80_0000, 32'h3F80_0000);   // 1.0 == 1.0 -> 1
    set_req(1, OP_LT, 32'h4000_0000, 32'h3F80_0000);   // 2.0 <  1.0 -> 0
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_valid", 32'(rsp_valid), 32'd1);
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
      chk("rr_y", 32'(rsp_y), (k % 2 == 0) ? 32'd1 : 32'd0);
      $display("txn rr k=%0d id=%0d y=%0d", k, rsp_id, rsp_y);
    end
    req_valid = '0;
    tick();
    chk("drain_valid", 32'(rsp_valid), 32'd0);

    // 1.0 < 2.0 on req0; req1 carries NaN operands but is not requesting
    set_req(0, OP_LT, 32'h3F80_0000, 32'h4000_0000);
    set_req(1, OP_RSV, 32'h7FC0_0000, 32'h7FC0_0000);
    req_valid = 2'b01;
    #1 chk("lt_grant", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    chk("lt_valid", 32'(rsp_valid), 32'd1);
    chk("lt_y", 32'(rsp_y), 32'd1);
    chk("lt_id", 32'(rsp_id), 32'd0);
    chk("lt_inv", 32'(rsp_inv), 32'd0);
    chk("lt_cnt", 32'(inv_cnt), 32'd0);
    $display("txn lt id=%0d y=%0d inv=%0d", rsp_id, rsp_y, rsp_inv);

    // req1: -0 == +0, then NaN < 1.0 back to back
    set_req(1, OP_EQ, 32'h8000_0000, 32'h0000_0000);
    req_valid = 2'b10;
    tick();
    chk("z_y", 32'(rsp_y), 32'd1);
    chk("z_id", 32'(rsp_id), 32'd1);
    chk("z_inv", 32'(rsp_inv), 32'd0);
    $display("txn zero id=%0d y=%0d inv=%0d", rsp_id, rsp_y, rsp_inv);
    set_req(1, OP_LT, 32'h7FC0_0000, 32'h3F80_0000);
    tick();
    chk("nan_y", 32'(rsp_y), 32'd0);
    chk("nan_id", 32'(rsp_id), 32'd1);
    chk("nan_inv", 32'(rsp_inv), 32'd1);
    chk("nan_cnt", 32'(inv_cnt), 32'd1);
    $display("txn nan id=%0d y=%0d inv=%0d cnt=%0d", rsp_id, rsp_y, rsp_inv, inv_cnt);
    req_valid = '0;
    tick();

    // Comparator corner vectors, one per cycle on req0
    for (int i = 0; i < NV; i++) begin
      set_req(0, v_op[i], v_x1[i], v_x2[i]);
      req_valid = 2'b01;
      tick();
      chk($sformatf("vec%0d_y", i), 32'(rsp_y), 32'(v_y[i]));
      chk($sformatf("vec%0d_inv", i), 32'(rsp_inv), 32'(v_inv[i]));
      $display("txn vec%0d op=%0d x1=%h x2=%h y=%0d inv=%0d", i, v_op[i], v_x1[i], v_x2[i], rsp_y, rsp_inv);
    end
    req_valid = '0;
    tick();
    chk("vec_cnt", 32'(inv_cnt), 32'd3);

    // Backpressure: output held stable for 3 cycles, then drain + refill
    set_req(0, OP_EQ, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    chk("bp_fill", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_ready", 32'(req_ready), 32'd0);
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_y", 32'(rsp_y), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd0);
      $display("txn stall k=%0d id=%0d y=%0d", k, rsp_id, rsp_y);
    end
    rsp_ready = 1'b1;
    req_valid = 2'b01;
    set_req(0, OP_LT, 32'h4000_0000, 32'h3F80_0000);   // 2.0 < 1.0 -> 0
    #1 chk("refill_grant", 32'(req_ready), 32'd1);
    tick();
    chk("refill_valid", 32'(rsp_valid), 32'd1);
    chk("refill_y", 32'(rsp_y), 32'd0);
    chk("refill_id", 32'(rsp_id), 32'd0);
    $display("txn refill id=%0d y=%0d", rsp_id, rsp_y);
    rsp_ready = 1'b0;
    req_valid = '0;

    // Reset while FULL (pointer at 1): result discarded, priority back to req0
    rst       = 1'b1;
    req_valid = 2'b11;
    #1 chk("rf_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("rf_valid", 32'(rsp_valid), 32'd0);
    chk("rf_cnt", 32'(inv_cnt), 32'd0);
    chk("rf_cnt2", 32'(inv_cnt2), 32'd0);
    set_req(0, OP_EQ, 32'h3F80_0000, 32'h3F80_0000);
    #1 chk("rf_grant", 32'(req_ready), 32'd1);
    tick();
    chk("rf_id", 32'(rsp_id), 32'd0);
    chk("rf_valid2", 32'(rsp_valid), 32'd1);
    $display("txn post_reset id=%0d y=%0d", rsp_id, rsp_y);
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();

    // Reserved opcode x5: CNT_W=2 counter saturates at 3
    set_req(0, OP_RSV, 32'h3F80_0000, 32'h3F80_0000);
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("sat_cnt", 32'(inv_cnt2), (k < 2) ? 32'(k + 1) : 32'd3);
      chk("rsv_inv", 32'(rsp_inv), 32'd1);
      chk("rsv_y", 32'(rsp_y), 32'd0);
      $display("txn rsv k=%0d cnt2=%0d", k, inv_cnt2);
    end
    chk("rsv_cnt16", 32'(inv_cnt), 32'd5);
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
